// File: rtl/alu_pkg.sv
// Shared definitions for the nibble-serial add/subtract engine.
//   SLICE_W  : width of the carry-lookahead slice (one nibble)
//   state_e  : engine FSM state encoding
//   flags_t  : result flag bundle returned alongside the sum
package alu_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic c_out;
        logic ovf;
        logic zero;
    } flags_t;

endpackage

// File: rtl/adder4_slice.sv
// 4-bit carry-lookahead adder slice (purely combinational).
//   A, B : nibble operands
//   C0   : carry into bit 0
//   F    : nibble sum
//   C4   : carry out of bit 3
module adder4_slice (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       C0,
    output logic [3:0] F,
    output logic       C4
);

    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    assign p = A ^ B;
    assign g = A & B;

    // Every carry is expanded directly from G/P and C0 so no carry
    // depends on the previous carry's gate output.
    assign c[0] = C0;
    assign c[1] = g[0] | (p[0] & C0);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & C0);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & C0);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & C0);

    assign F  = p ^ c[3:0];
    assign C4 = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit add/subtract engine. One 4-bit lookahead slice is
// reused for every nibble, LSB nibble first, with the carry held in a register
// between steps. Operands arrive and results leave over valid/ready.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : operand handshake (in_ready high only in IDLE)
//   a, b, sub, c_in       : operands; sub=1 computes a-b and ignores c_in
//   out_valid / out_ready : result handshake (out_valid high only in DONE)
//   sum, c_out, ovf, zero : registered result and flags, held until next accept
module nibble_serial_adder
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] a_q,     a_d;
    logic [WIDTH-1:0] b_q,     b_d;      // already inverted for subtract
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q,   sum_d;
    flags_t           flags_q, flags_d;

    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_f;
    logic               slice_c4;

    // The counter steers which nibble of the operand registers feeds the slice.
    assign slice_a = a_q[cnt_q*SLICE_W +: SLICE_W];
    assign slice_b = b_q[cnt_q*SLICE_W +: SLICE_W];

    adder4_slice u_slice (
        .A  (slice_a),
        .B  (slice_b),
        .C0 (carry_q),
        .F  (slice_f),
        .C4 (slice_c4)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            flags_q <= flags_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets a hold-value default first, so no branch
        // can leave one unassigned and infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        flags_d = flags_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtract is a + ~b + 1: invert b here, force carry-in.
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = sub | c_in;
                    sum_d   = '0;
                    flags_d = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                sum_d[cnt_q*SLICE_W +: SLICE_W] = slice_f;
                carry_d = slice_c4;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    // Flags use the sum including the nibble written this cycle.
                    flags_d.c_out = slice_c4;
                    flags_d.ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1])
                                  & (sum_d[WIDTH-1] != a_q[WIDTH-1]);
                    flags_d.zero  = ~|sum_d;
                    cnt_d         = '0;
                    state_d       = DONE;
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign c_out     = flags_q.c_out;
    assign ovf       = flags_q.ovf;
    assign zero      = flags_q.zero;

endmodule
